gpio_modport: RTL and testbench

APB-slave general-purpose I/O controller with 32 bidirectional pads, per-bit auxiliary-input muxing, edge-triggered interrupts and optional external-clock input sampling. Sits on the peripheral APB bus; drives `io_pad` to the chip boundary and raises `irq` to the interrupt controller. Register map follows the team's standard RGPIO layout.

---
 rtl/gpio_modport.sv | 170 +++++++++++++++++
 tb/tb_gpio_modport.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_modport.sv
// gpio_modport: APB-slave GPIO controller with 32 bidirectional pads,
// per-bit auxiliary output muxing, edge-triggered interrupts and an
// optional external-clock sampling path.
// Build option: define GPIO_ECLK_EN to include the RGPIO_ECLK/RGPIO_NEC
// registers and the ext_clk_pad_i sampling path.
module gpio_modport (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    input  logic        ext_clk_pad_i,
    input  logic [31:0] aux_in,
    inout  wire  [31:0] io_pad,
    output logic        irq
);

    logic [31:0] rgpio_out;
    logic [31:0] rgpio_oe;
    logic [31:0] rgpio_inte;
    logic [31:0] rgpio_ptrig;
    logic [31:0] rgpio_aux;
    logic        ctrl_inte;
    logic [31:0] rgpio_ints;
    logic [31:0] rgpio_in;
    logic [31:0] in_prev;
    logic [31:0] pad_s1;
    logic [31:0] pad_s2;
    logic [31:0] sample_en;
    logic [31:0] ints_set;
    logic [31:0] pad_drive;
    logic [3:0]  reg_sel;
    logic        wr_en;
    logic        rd_en;

    assign reg_sel = paddr[5:2];
    assign wr_en   = psel & penable & pwrite;
    assign rd_en   = psel & penable & ~pwrite;
    assign pready  = 1'b1;

`ifdef GPIO_ECLK_EN
    logic [31:0] rgpio_eclk;
    logic [31:0] rgpio_nec;
    logic        ext_s1;
    logic        ext_s2;
    logic        ext_prev;
    logic        ext_rise;
    logic        ext_fall;
    logic        unused_bits;

    assign unused_bits = ^{paddr[31:6], paddr[1:0]};

    // External sampling clock is treated as data: two-flop sync plus a delayed copy for edge detect
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ext_s1     <= 1'b0;
            ext_s2     <= 1'b0;
            ext_prev   <= 1'b0;
            rgpio_eclk <= '0;
            rgpio_nec  <= '0;
        end else begin
            ext_s1   <= ext_clk_pad_i;
            ext_s2   <= ext_s1;
            ext_prev <= ext_s2;
            if (wr_en && reg_sel == 4'h8) rgpio_eclk <= pwdata;
            if (wr_en && reg_sel == 4'h9) rgpio_nec  <= pwdata;
        end
    end

    assign ext_rise  = ext_s2 & ~ext_prev;
    assign ext_fall  = ~ext_s2 & ext_prev;
    assign sample_en = ~rgpio_eclk
                     | (rgpio_nec  & {32{ext_fall}})
                     | (~rgpio_nec & {32{ext_rise}});
`else
    logic unused_bits;

    assign unused_bits = ^{paddr[31:6], paddr[1:0], ext_clk_pad_i};
    assign sample_en   = '1;
`endif

    // Software-writable configuration registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rgpio_out   <= '0;
            rgpio_oe    <= '0;
            rgpio_inte  <= '0;
            rgpio_ptrig <= '0;
            rgpio_aux   <= '0;
            ctrl_inte   <= 1'b0;
        end else if (wr_en) begin
            case (reg_sel)
                4'h1:    rgpio_out   <= pwdata;
                4'h2:    rgpio_oe    <= pwdata;
                4'h3:    rgpio_inte  <= pwdata;
                4'h4:    rgpio_ptrig <= pwdata;
                4'h5:    rgpio_aux   <= pwdata;
                4'h6:    ctrl_inte   <= pwdata[0];
                default: ;
            endcase
        end
    end

    // Pad synchronizer and RGPIO_IN capture; bits in external-clock mode hold until their selected edge
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pad_s1   <= '0;
            pad_s2   <= '0;
            rgpio_in <= '0;
            in_prev  <= '0;
        end else begin
            pad_s1   <= io_pad;
            pad_s2   <= pad_s1;
            rgpio_in <= (pad_s2 & sample_en) | (rgpio_in & ~sample_en);
            in_prev  <= rgpio_in;
        end
    end

    assign ints_set = rgpio_inte & ((rgpio_ptrig  & rgpio_in  & ~in_prev)
                                  | (~rgpio_ptrig & ~rgpio_in &  in_prev));

    // Interrupt status: a hardware set always wins over a same-cycle software write
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rgpio_ints <= '0;
        end else if (wr_en && reg_sel == 4'h7) begin
            rgpio_ints <= pwdata | ints_set;
        end else begin
            rgpio_ints <= rgpio_ints | ints_set;
        end
    end

    assign irq = ctrl_inte & (|rgpio_ints);

    // Read mux, only driven during the access phase of a read
    always_comb begin
        prdata = '0;
        if (rd_en) begin
            case (reg_sel)
                4'h0:    prdata = rgpio_in;
                4'h1:    prdata = rgpio_out;
                4'h2:    prdata = rgpio_oe;
                4'h3:    prdata = rgpio_inte;
                4'h4:    prdata = rgpio_ptrig;
                4'h5:    prdata = rgpio_aux;
                4'h6:    prdata = {30'b0, |rgpio_ints, ctrl_inte};
                4'h7:    prdata = rgpio_ints;
`ifdef GPIO_ECLK_EN
                4'h8:    prdata = rgpio_eclk;
                4'h9:    prdata = rgpio_nec;
`endif
                default: prdata = '0;
            endcase
        end
    end

    assign pad_drive = (rgpio_aux & aux_in) | (~rgpio_aux & rgpio_out);

    genvar g;
    generate
        for (g = 0; g < 32; g++) begin : g_pad
            assign io_pad[g] = rgpio_oe[g] ? pad_drive[g] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_gpio_modport.sv
// tb_gpio_modport: directed scoreboard bench for gpio_modport.
// Pads carry pull-ups so an undriven (Z) pad reads back as 1.
// Define GPIO_ECLK_EN to also exercise the external-clock sampling path.
module tb_gpio_modport;

    logic        pclk;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        ext_clk_pad_i;
    logic [31:0] aux_in;
    wire  [31:0] io_pad;
    logic        irq;
    logic        tb_en;
    logic [31:0] tb_val;

    int          vectors;
    int          miscompares;
    logic [31:0] sb_q[$];

    gpio_modport dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .psel          (psel),
        .penable       (penable),
        .pwrite        (pwrite),
        .paddr         (paddr),
        .pwdata        (pwdata),
        .prdata        (prdata),
        .pready        (pready),
        .ext_clk_pad_i (ext_clk_pad_i),
        .aux_in        (aux_in),
        .io_pad        (io_pad),
        .irq           (irq)
    );

    assign io_pad = tb_en ? tb_val : 32'bz;

    genvar g;
    generate
        for (g = 0; g < 32; g++) begin : g_pu
            pullup pu (io_pad[g]);
        end
    endgenerate

    // Free-running 100 MHz clock
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Pop the oldest expectation and compare it with what the DUT produced
    task automatic checkOutput(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h with no expected value queued", tag, observed);
        end else begin
            expected = sb_q.pop_front();
            assert (observed === expected) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            end
        end
    endtask

    // Queue an expectation for a directly observed signal and check it
    task automatic checkSignal(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        sb_q.push_back(expected);
        checkOutput(tag, observed);
    endtask

    // One APB transfer; for reads, data is the expected read value
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data);
        @(negedge pclk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wr ? data : 32'h0;
        if (!wr) sb_q.push_back(data);
        @(negedge pclk);
        penable = 1'b1;
        if (!wr) begin
            #1;
            checkOutput($sformatf("read@%02h", addr[7:0]), prdata);
        end
        @(negedge pclk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    // Directed test sequence
    initial begin
        vectors       = 0;
        miscompares   = 0;
        presetn       = 1'b0;
        psel          = 1'b0;
        penable       = 1'b0;
        pwrite        = 1'b0;
        paddr         = '0;
        pwdata        = '0;
        ext_clk_pad_i = 1'b0;
        aux_in        = '0;
        tb_en         = 1'b1;
        tb_val        = '0;

        repeat (2) @(negedge pclk);
        #1;
        checkSignal("irq_reset", {31'b0, irq}, 32'h0);
        checkSignal("pready_reset", {31'b0, pready}, 32'h1);
        @(negedge pclk);
        presetn = 1'b1;

        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 32'(i * 4), 32'h0);

        tb_en = 1'b0;
        #1;
        checkSignal("pad_z_reset", io_pad, 32'hFFFF_FFFF);

        applyStimulus(1'b1, 32'h04, 32'hA5A5_5A5A);
        applyStimulus(1'b1, 32'h08, 32'hFFFF_FFFF);
        #1;
        checkSignal("pad_out", io_pad, 32'hA5A5_5A5A);
        applyStimulus(1'b0, 32'h04, 32'hA5A5_5A5A);
        applyStimulus(1'b0, 32'h08, 32'hFFFF_FFFF);

        aux_in = 32'h0000_0033;
        applyStimulus(1'b1, 32'h14, 32'h0000_00FF);
        applyStimulus(1'b1, 32'h04, 32'h0000_0000);
        applyStimulus(1'b1, 32'h08, 32'h0000_00FF);
        #1;
        checkSignal("pad_aux", io_pad, 32'hFFFF_FF33);
        applyStimulus(1'b0, 32'h14, 32'h0000_00FF);

        applyStimulus(1'b1, 32'h08, 32'h0000_0000);
        tb_en  = 1'b1;
        tb_val = 32'h0;
        repeat (4) @(negedge pclk);
        tb_val = 32'h1234_5678;
        applyStimulus(1'b0, 32'h00, 32'h0000_0000);
        applyStimulus(1'b0, 32'h00, 32'h1234_5678);

        applyStimulus(1'b1, 32'h0C, 32'h0000_0001);
        applyStimulus(1'b1, 32'h10, 32'h0000_0001);
        applyStimulus(1'b1, 32'h18, 32'h0000_0001);
        applyStimulus(1'b0, 32'h18, 32'h0000_0001);
        tb_val = 32'h1234_5679;
        repeat (3) @(negedge pclk);
        #1;
        checkSignal("irq_early", {31'b0, irq}, 32'h0);
        @(negedge pclk);
        #1;
        checkSignal("irq_rise", {31'b0, irq}, 32'h1);
        applyStimulus(1'b0, 32'h1C, 32'h0000_0001);
        applyStimulus(1'b0, 32'h18, 32'h0000_0003);
        applyStimulus(1'b1, 32'h1C, 32'h0000_0000);
        #1;
        checkSignal("irq_cleared", {31'b0, irq}, 32'h0);

        tb_val = 32'h1234_5678;
        repeat (6) @(negedge pclk);
        #1;
        checkSignal("irq_fall", {31'b0, irq}, 32'h0);
        applyStimulus(1'b0, 32'h1C, 32'h0000_0000);

        tb_val = 32'h1234_5679;
        repeat (6) @(negedge pclk);
        #1;
        checkSignal("irq_rise2", {31'b0, irq}, 32'h1);
        applyStimulus(1'b1, 32'h18, 32'h0000_0002);
        #1;
        checkSignal("irq_gated", {31'b0, irq}, 32'h0);
        applyStimulus(1'b0, 32'h18, 32'h0000_0002);
        applyStimulus(1'b0, 32'h1C, 32'h0000_0001);

        applyStimulus(1'b1, 32'h00, 32'h0000_0000);
        applyStimulus(1'b0, 32'h00, 32'h1234_5679);
        applyStimulus(1'b1, 32'h28, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 32'h28, 32'h0000_0000);

`ifdef GPIO_ECLK_EN
        applyStimulus(1'b1, 32'h20, 32'h0000_0001);
        applyStimulus(1'b1, 32'h24, 32'h0000_0000);
        applyStimulus(1'b0, 32'h20, 32'h0000_0001);
        tb_val = 32'h1234_5678;
        repeat (6) @(negedge pclk);
        applyStimulus(1'b0, 32'h00, 32'h1234_5679);
        ext_clk_pad_i = 1'b1;
        repeat (4) @(negedge pclk);
        applyStimulus(1'b0, 32'h00, 32'h1234_5678);
        ext_clk_pad_i = 1'b0;
`endif

        @(negedge pclk);
        psel    = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h04;
        pwdata  = 32'hDEAD_BEEF;
        @(negedge pclk);
        penable = 1'b1;
        #2;
        presetn = 1'b0;
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        applyStimulus(1'b0, 32'h04, 32'h0000_0000);
        applyStimulus(1'b0, 32'h1C, 32'h0000_0000);
        #1;
        checkSignal("irq_after_reset", {31'b0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
